open_list_min_scan: RTL and testbench
=====================================

Name: open_list_min_scan

Overview:
- Reader-side engine for the loop-queue node store in the A* search path.
- Walks entries 0..count-1 of a synchronous-read queue memory and reports the minimum stored value and its address. The search controller uses this to pick the next open node.
- Drives the queue's read address and consumes its registered read data. It never writes the queue.

Parameters:
- DATA_WIDTH, 8: width of each queue entry (cost value).
- ADDR_WIDTH, 4: queue address width; depth is 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- count  input  ADDR_WIDTH+1  number of entries to scan, sampled with start.
- rd_addr  output  ADDR_WIDTH  registered read address to queue addr_in.
- rd_data  input  DATA_WIDTH  queue data_out; valid one cycle after rd_addr.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when results are valid.
- empty  output  1  last scan found no eligible entry.
- min_data  output  DATA_WIDTH  minimum value from the last scan.
- min_addr  output  ADDR_WIDTH  address of min_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State returns to IDLE.
  - rd_addr=0, busy=0, done=0, empty=1, min_data=all-ones, min_addr=0.
  - A scan in flight is aborted and produces no done.
- Ready condition: the engine is ready to accept start when busy=0, including the done cycle.
- FSM states:
  - IDLE: on start, count is clamped to 2^ADDR_WIDTH and latched as N.
    - If N=0: go to FIN.
    - Otherwise: rd_addr<=0, the running minimum is reset to all-ones, busy<=1, go to SCAN.
  - SCAN: rd_addr increments by 1 each cycle until it reaches N-1, then holds.
    - A one-stage pipe (pipe_valid, pipe_addr) tracks which address the current rd_data belongs to.
    - Each cycle with pipe_valid=1, rd_data is compared against the running minimum.
    - When address N-1 has been issued, go to DRAIN.
  - DRAIN: finishes comparisons for entries still in the pipe, then goes to FIN.
  - FIN: drives done=1 for one cycle, busy<=0, updates the result outputs, returns to IDLE.
- Latency (N>=1): done is high in the cycle following the (N+1)th rising edge after the edge that sampled start.
- Latency (N=0): done is high in the cycle following the first edge after start was sampled. It reports empty=1, min_data=all-ones, min_addr=0.
- Compare rule:
  - The running minimum is replaced only on a strict less-than.
  - Ties keep the lower address.
  - A value equal to all-ones still counts as eligible, so empty=0 whenever N>=1. The exception is when the optional feature excludes entries.
- Output stability: min_data, min_addr and empty change only in the done cycle and hold until the next done or reset.
- Width: count is ADDR_WIDTH+1 bits so that a full queue (2^ADDR_WIDTH entries) is expressible. rd_addr never wraps past N-1.
- Simultaneous events:
  - start while busy=1 is ignored, not queued.
  - start in the done cycle is accepted, and the new scan begins on the next edge.
- Concurrent writes:
  - Queue writes during a scan are not snapshotted; each entry's value is whatever the queue returns when it is read.
  - A write to the address currently being read returns the written data, which is the queue's write-through behaviour.

Optional Feature:
- Macro: MIN_SCAN_SKIP_ZERO_EN.
- Defined: entries equal to 0 are treated as free slots.
  - Zero entries are excluded from the comparison.
  - empty=1 if no nonzero entry exists among 0..N-1; in that case min_data=all-ones and min_addr=0.
- Undefined: 0 is an ordinary value and is the smallest possible minimum. Excluded-entry logic is absent.

Test Plan:
- Reset mid-scan: entries {9,4,7}, start with count=3, pull rst_n low two cycles later -> busy=0, done never pulses, outputs at reset values, next scan runs normally.
- Basic scan: entries {9,4,7,4}, count=4 -> done 5 edges after start; min_data=4, min_addr=1, empty=0, rd_addr sequence 0,1,2,3.
- Full depth: 16 entries with value 20-i, count=16 -> min_data=5, min_addr=15; rd_addr never exceeds 15.
- count=0: start with count=0 -> done one cycle later, empty=1, min_data=8'hFF, min_addr=0.
- Busy/back-to-back: assert start during a scan -> ignored; assert start in the done cycle -> second scan accepted, busy stays high, correct second result.
- MIN_SCAN_SKIP_ZERO_EN: entries {0,0,6,3}, count=4 -> defined: min_data=3, min_addr=3; undefined: min_data=0, min_addr=0. Entries all 0 with the macro defined -> empty=1.

Source files
------------

// File: rtl/open_list_min_scan.sv
// Minimum-value scanner over a synchronous-read queue: reports the smallest entry among 0..count-1 and its address.
// Optional MIN_SCAN_SKIP_ZERO_EN: zero entries are treated as free slots and excluded from the search.
module open_list_min_scan #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] min_data,
  output logic [ADDR_WIDTH-1:0] min_addr
);

  // state | meaning
  // IDLE  | waiting for start
  // SCAN  | issuing read addresses 0..N-1
  // DRAIN | comparing the last entry still in the read pipe
  // FIN   | done pulse; results valid; start accepted here too
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH:0]     n_clamp;
  logic [ADDR_WIDTH-1:0]   last_addr, last_nxt;
  logic                    accept;
  logic                    pipe_valid;
  logic [ADDR_WIDTH-1:0]   pipe_addr;
  logic [DATA_WIDTH-1:0]   run_min, cand_min;
  logic [ADDR_WIDTH-1:0]   run_addr, cand_addr;
  logic                    run_found, cand_found;
  logic                    eligible, take;

  assign accept   = start && (state == IDLE || state == FIN);
  assign n_clamp  = (count > DEPTH) ? DEPTH : count;
  // N = 2^ADDR_WIDTH has zero low bits, so the truncated subtract still yields the top address.
  assign last_nxt = n_clamp[ADDR_WIDTH-1:0] - 1'b1;

  assign busy = (state == SCAN) || (state == DRAIN);
  assign done = (state == FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (accept)
          state_nxt = (n_clamp == '0) ? FIN : SCAN;
        else
          state_nxt = IDLE;
      end
      SCAN:    if (rd_addr == last_addr) state_nxt = DRAIN;
      DRAIN:   state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef MIN_SCAN_SKIP_ZERO_EN
    eligible = pipe_valid && (rd_data != '0);
`else
    eligible = pipe_valid;
`endif
    // The first eligible entry always lands so an all-ones value still records its address.
    take       = eligible && (!run_found || (rd_data < run_min));
    cand_min   = take ? rd_data : run_min;
    cand_addr  = take ? pipe_addr : run_addr;
    cand_found = run_found || eligible;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_addr    <= '0;
      last_addr  <= '0;
      pipe_valid <= 1'b0;
      pipe_addr  <= '0;
      run_min    <= '1;
      run_addr   <= '0;
      run_found  <= 1'b0;
      empty      <= 1'b1;
      min_data   <= '1;
      min_addr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_addr    <= '0;
        last_addr  <= last_nxt;
        pipe_valid <= 1'b0;
        run_min    <= '1;
        run_addr   <= '0;
        run_found  <= 1'b0;
        if (n_clamp == '0) begin
          empty    <= 1'b1;
          min_data <= '1;
          min_addr <= '0;
        end
      end else if (state == SCAN) begin
        pipe_valid <= 1'b1;
        pipe_addr  <= rd_addr;
        if (rd_addr != last_addr) rd_addr <= rd_addr + 1'b1;
        run_min    <= cand_min;
        run_addr   <= cand_addr;
        run_found  <= cand_found;
      end else if (state == DRAIN) begin
        pipe_valid <= 1'b0;
        run_min    <= cand_min;
        run_addr   <= cand_addr;
        run_found  <= cand_found;
        empty      <= !cand_found;
        min_data   <= cand_min;
        min_addr   <= cand_addr;
      end
    end
  end

endmodule

// File: tb/tb_open_list_min_scan.sv
// Directed bench for open_list_min_scan with a behavioural synchronous-read queue.
module tb_open_list_min_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] count = '0;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy, done, empty;
  logic [7:0] min_data;
  logic [3:0] min_addr;

  logic [7:0] mem [16];
  int n_pass = 0;
  int n_chk  = 0;
  int done_cnt = 0;
  logic [3:0] addr_log [64];
  logic       busy_log [64];
  logic       done_at_start;
  int lat;
  int max_addr;

  open_list_min_scan #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .empty(empty), .min_data(min_data), .min_addr(min_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic fill(input logic [7:0] v0, input logic [7:0] v1,
                      input logic [7:0] v2, input logic [7:0] v3);
    mem[0] = v0; mem[1] = v1; mem[2] = v2; mem[3] = v3;
  endtask

  // Returns at #1 after the edge where done is seen; lat counts edges after the one that took start.
  task automatic run_scan(input int c, input int inject_at, output int lat_o);
    lat_o = -1;
    max_addr = 0;
    @(negedge clk);
    done_at_start = done;
    start = 1'b1;
    count = 5'(c);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == inject_at) begin
        start = 1'b1;
        count = 5'd1;
      end else if (k == inject_at + 1) begin
        start = 1'b0;
      end
      addr_log[k] = rd_addr;
      busy_log[k] = busy;
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      if (done) begin
        lat_o = k;
        break;
      end
    end
    start = 1'b0;
    if (lat_o < 0) chk("done_timeout", 32'(lat_o), 32'(c + 1));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_empty", empty, 1);
    chk("rst_min_data", min_data, 8'hFF);
    chk("rst_min_addr", min_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);

    // Reset in the middle of a scan
    fill(8'd9, 8'd4, 8'd7, 8'd4);
    @(negedge clk);
    start = 1'b1; count = 5'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_empty", empty, 1);
    chk("abort_min_data", min_data, 8'hFF);
    chk("abort_rd_addr", rd_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);

    // Basic scan with a tie at addresses 1 and 3
    run_scan(4, -1, lat);
    chk("basic_lat", lat, 5);
    chk("basic_min_data", min_data, 4);
    chk("basic_min_addr", min_addr, 1);
    chk("basic_empty", empty, 0);
    for (int k = 0; k < 4; k++) chk("basic_rd_addr", addr_log[k], k);
    chk("basic_rd_hold", addr_log[4], 3);
    chk("basic_busy_done", busy, 0);

    // Outputs hold through the next scan until its done
    fill(8'd50, 8'd60, 8'd2, 8'd0);
    run_scan(2, -1, lat);
    chk("hold_then_update", min_data, 50);
    chk("hold_lat", lat, 3);

    // Full depth and clamping of an oversized count
    for (int i = 0; i < 16; i++) mem[i] = 8'(20 - i);
    run_scan(16, -1, lat);
    chk("full_lat", lat, 17);
    chk("full_min_data", min_data, 5);
    chk("full_min_addr", min_addr, 15);
    chk("full_max_addr", max_addr, 15);
    run_scan(31, -1, lat);
    chk("clamp_lat", lat, 17);
    chk("clamp_min_addr", min_addr, 15);
    chk("clamp_max_addr", max_addr, 15);

    // Empty scan
    run_scan(0, -1, lat);
    chk("zero_lat", lat, 0);
    chk("zero_empty", empty, 1);
    chk("zero_min_data", min_data, 8'hFF);
    chk("zero_min_addr", min_addr, 0);
    chk("zero_busy", busy_log[0], 0);

    // All-ones entries are still eligible
    fill(8'hFF, 8'hFF, 8'd1, 8'd1);
    run_scan(2, -1, lat);
    chk("ones_empty", empty, 0);
    chk("ones_min_data", min_data, 8'hFF);
    chk("ones_min_addr", min_addr, 0);

    // Start while busy is ignored; start in the done cycle is taken
    fill(8'd9, 8'd4, 8'd7, 8'd4);
    run_scan(4, 2, lat);
    chk("inject_lat", lat, 5);
    chk("inject_min_addr", min_addr, 1);
    run_scan(1, -1, lat);
    chk("b2b_in_done", done_at_start, 1);
    chk("b2b_busy", busy_log[0], 1);
    chk("b2b_lat", lat, 2);
    chk("b2b_min_data", min_data, 9);
    chk("b2b_min_addr", min_addr, 0);

    // Zero entries: free slots with the option, ordinary minimum without
    fill(8'd0, 8'd0, 8'd6, 8'd3);
    run_scan(4, -1, lat);
`ifdef MIN_SCAN_SKIP_ZERO_EN
    chk("zeros_min_data", min_data, 3);
    chk("zeros_min_addr", min_addr, 3);
`else
    chk("zeros_min_data", min_data, 0);
    chk("zeros_min_addr", min_addr, 0);
`endif
    fill(8'd0, 8'd0, 8'd0, 8'd0);
    run_scan(4, -1, lat);
`ifdef MIN_SCAN_SKIP_ZERO_EN
    chk("allzero_empty", empty, 1);
    chk("allzero_min_data", min_data, 8'hFF);
`else
    chk("allzero_empty", empty, 0);
    chk("allzero_min_data", min_data, 0);
`endif
    chk("allzero_min_addr", min_addr, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
